// File: rtl/apb_req_arbiter_if.sv
// Bundle between the requester-side / APB-side logic and the request arbiter.
// The arbiter uses the master modport; the environment driving requesters and the slave uses slave.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  // Requester handshake: req[i] is raised with its addr/wr/wdata and held until
  // done[i] pulses; the arbiter captures the fields at grant, so later changes
  // (including dropping req) do not affect a transfer already in flight.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         addr_out;
  logic                      wr_out;
  logic                      sel_out;
  logic                      enable_out;
  logic [DATA_W-1:0]         data_out;
  logic                      ready_in;
  logic [DATA_W-1:0]         rdata_in;
  logic [1:0]                state_dbg;

  modport master (
    input  req, req_addr, req_wr, req_wdata, ready_in, rdata_in,
    output done, err, rdata, busy, addr_out, wr_out, sel_out, enable_out,
           data_out, state_dbg
  );

  modport slave (
    output req, req_addr, req_wr, req_wdata, ready_in, rdata_in,
    input  done, err, rdata, busy, addr_out, wr_out, sel_out, enable_out,
           data_out, state_dbg
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin front end that serialises NUM_REQ local requesters onto one APB
// master port, sequencing IDLE/SETUP/ACCESS with a bounded wait for ready_in.
module apb_req_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  apb_req_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  assign bus.state_dbg = state;
  assign owner_next = (int'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);

  // Scan downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      wait_cnt       <= '0;
      bus.done       <= '0;
      bus.err        <= 1'b0;
      bus.rdata      <= '0;
      bus.busy       <= 1'b0;
      bus.addr_out   <= '0;
      bus.wr_out     <= 1'b0;
      bus.sel_out    <= 1'b0;
      bus.enable_out <= 1'b0;
      bus.data_out   <= '0;
    end else begin
      bus.done <= '0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          // Skip the cycle in which done is shown so the finished owner can drop req.
          if (pick_valid && (bus.done == '0)) begin
            owner          <= pick_idx;
            bus.addr_out   <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            bus.wr_out     <= bus.req_wr[pick_idx];
            bus.data_out   <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            bus.sel_out    <= 1'b1;
            bus.enable_out <= 1'b0;
            bus.busy       <= 1'b1;
            state          <= SETUP;
          end
        end
        SETUP: begin
          bus.enable_out <= 1'b1;
          wait_cnt       <= '0;
          state          <= ACCESS;
        end
        ACCESS: begin
          if (bus.ready_in) begin
            bus.done[owner] <= 1'b1;
            if (!bus.wr_out) begin
              bus.rdata <= bus.rdata_in;
            end
            bus.sel_out    <= 1'b0;
            bus.enable_out <= 1'b0;
            bus.busy       <= 1'b0;
            rr_ptr         <= owner_next;
            state          <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.done[owner] <= 1'b1;
            bus.err         <= 1'b1;
            bus.sel_out     <= 1'b0;
            bus.enable_out  <= 1'b0;
            bus.busy        <= 1'b0;
            rr_ptr          <= owner_next;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: phase checks plus a scoreboard of expected
// completions {done, err, rdata} consumed whenever done pulses.
module tb_apb_req_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int EXP_W   = NUM_REQ + 1 + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check("sb_done", 64'(bus.done), 64'(e[EXP_W-1 -: NUM_REQ]));
          check("sb_err", 64'(bus.err), 64'(e[DATA_W]));
          check("sb_rdata", 64'(bus.rdata), 64'(e[DATA_W-1:0]));
        end
      end else begin
        check("err_without_done", 64'(bus.err), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic w,
                         input logic [DATA_W-1:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wr[i]                     = w;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_done(input logic [NUM_REQ-1:0] oh, input logic e);
    exp_q.push_back({oh, e, model_rdata});
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done != '0) break;
    end
    check(tag, 64'(bus.done != '0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.done, bus.err, bus.busy, bus.sel_out, bus.enable_out, bus.wr_out,
                bus.addr_out, bus.state_dbg}, 64'd0);
    check({tag, "_data"}, {bus.data_out, bus.rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc;
    int en_cnt;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_wr    = '0;
    bus.req_wdata = '0;
    bus.ready_in  = 1'b0;
    bus.rdata_in  = '0;

    // Reset values while reset is held.
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // Single zero-wait write to requester 0.
    bus.ready_in = 1'b1;
    set_req(0, 12'h500, 1'b1, 32'd9);
    expect_done(3'b001, 1'b0);
    bus.req = 3'b001;
    tick();
    check("wr_setup_sel", 64'(bus.sel_out), 64'd1);
    check("wr_setup_en", 64'(bus.enable_out), 64'd0);
    check("wr_setup_busy", 64'(bus.busy), 64'd1);
    tick();
    check("wr_access_en", 64'(bus.enable_out), 64'd1);
    check("wr_access_sel", 64'(bus.sel_out), 64'd1);
    check("wr_access_addr", 64'(bus.addr_out), 64'h500);
    check("wr_access_data", 64'(bus.data_out), 64'd9);
    check("wr_access_wr", 64'(bus.wr_out), 64'd1);
    tick();
    check("wr_done_t3", 64'(bus.done), 64'b001);
    check("wr_busy_drop", 64'(bus.busy), 64'd0);
    bus.req = '0;
    tick();

    // Read with two wait states on requester 1.
    bus.ready_in = 1'b0;
    set_req(1, 12'h600, 1'b0, 32'd0);
    model_rdata = 32'hDEADBEEF;
    expect_done(3'b010, 1'b0);
    bus.req = 3'b010;
    tick();
    tick();
    tick();
    check("rd_wait_en", 64'(bus.enable_out), 64'd1);
    tick();
    bus.ready_in = 1'b1;
    bus.rdata_in = 32'hDEADBEEF;
    tick();
    check("rd_done_t5", 64'(bus.done), 64'b010);
    check("rd_rdata", 64'(bus.rdata), 64'hDEADBEEF);
    bus.req      = '0;
    bus.rdata_in = 32'h0BAD_0BAD;
    tick();

    // Round-robin with all requesters held; next grant starts from requester 2.
    set_req(0, 12'h010, 1'b1, 32'h10);
    set_req(1, 12'h120, 1'b1, 32'h20);
    set_req(2, 12'h230, 1'b1, 32'h30);
    expect_done(3'b100, 1'b0);
    expect_done(3'b001, 1'b0);
    expect_done(3'b010, 1'b0);
    expect_done(3'b100, 1'b0);
    bus.req  = 3'b111;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(20, "rr_wait");
      if (k > 0) check("rr_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
    end
    bus.req = '0;
    tick();

    // Timeout: ready stuck low, requester 2 (rr_ptr now 0, only 2 requesting).
    bus.ready_in = 1'b0;
    set_req(2, 12'h7A0, 1'b1, 32'h55);
    expect_done(3'b100, 1'b1);
    bus.req = 3'b100;
    en_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done != '0) break;
      if (bus.enable_out) en_cnt++;
    end
    check("to_en_cycles", 64'(en_cnt), 64'(TIMEOUT));
    check("to_done", 64'(bus.done), 64'b100);
    check("to_err", 64'(bus.err), 64'd1);
    check("to_rdata_kept", 64'(bus.rdata), 64'hDEADBEEF);
    bus.req = '0;
    tick();

    // Normal read after timeout.
    bus.ready_in = 1'b1;
    bus.rdata_in = 32'h12345678;
    set_req(0, 12'h044, 1'b0, 32'd0);
    model_rdata = 32'h12345678;
    expect_done(3'b001, 1'b0);
    bus.req = 3'b001;
    wait_done(10, "post_to_wait");
    check("post_to_rdata", 64'(bus.rdata), 64'h12345678);
    bus.req = '0;
    tick();

    // Asynchronous reset in the middle of ACCESS.
    bus.ready_in = 1'b0;
    set_req(0, 12'h100, 1'b1, 32'd1);
    bus.req = 3'b001;
    tick();
    tick();
    check("mid_access_state", 64'(bus.state_dbg), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_rdata = '0;
    set_req(1, 12'h200, 1'b1, 32'd2);
    set_req(2, 12'h300, 1'b1, 32'd3);
    bus.ready_in = 1'b1;
    bus.req      = 3'b110;
    expect_done(3'b010, 1'b0);
    expect_done(3'b100, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_done(10, "after_reset_wait1");
    check("after_reset_first", 64'(bus.done), 64'b010);
    bus.req = 3'b100;
    wait_done(10, "after_reset_wait2");
    check("after_reset_second", 64'(bus.done), 64'b100);
    bus.req = '0;
    tick();

    // Requester fields change during SETUP; the latched transfer must not move.
    set_req(0, 12'h500, 1'b1, 32'hA5);
    expect_done(3'b001, 1'b0);
    bus.req = 3'b001;
    tick();
    set_req(0, 12'h600, 1'b1, 32'hFF);
    check("chg_setup_addr", 64'(bus.addr_out), 64'h500);
    tick();
    check("chg_access_addr", 64'(bus.addr_out), 64'h500);
    check("chg_access_data", 64'(bus.data_out), 64'hA5);
    tick();
    check("chg_done", 64'(bus.done), 64'b001);
    check("chg_done_addr", 64'(bus.addr_out), 64'h500);
    bus.req = '0;

    // Random zero/short-wait transfers from single requesters.
    for (int n = 0; n < 6; n++) begin
      int r;
      logic w;
      logic [DATA_W-1:0] d;
      tick();
      r = $urandom_range(NUM_REQ - 1, 0);
      w = 1'($urandom_range(1, 0));
      d = $urandom;
      bus.ready_in = 1'b1;
      bus.rdata_in = d;
      set_req(r, 12'($urandom_range(4095, 0)), w, d);
      if (!w) model_rdata = d;
      expect_done(NUM_REQ'(1) << r, 1'b0);
      bus.req = NUM_REQ'(1) << r;
      wait_done(10, "rand_wait");
      bus.req = '0;
    end

    repeat (3) tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
